// File: rtl/piece_motion_scheduler_pkg.sv
// Shared definitions for the falling-piece motion scheduler.
// - state_t     : scheduler FSM states
// - COL_*       : 3-bit RGB sprite colours
// - STEP_DEF    : default pixel step for horizontal and vertical moves
// - next_colour : piece colour rotation 100->010->001->110->011->101->100
package piece_motion_scheduler_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SPAWN, ST_FALLING, ST_LANDED} state_t;

  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  localparam int STEP_DEF = 32;

  function automatic logic [2:0] next_colour(input logic [2:0] c);
    case (c)
      COL_RED:     next_colour = COL_GREEN;
      COL_GREEN:   next_colour = COL_BLUE;
      COL_BLUE:    next_colour = COL_YELLOW;
      COL_YELLOW:  next_colour = COL_CYAN;
      COL_CYAN:    next_colour = COL_MAGENTA;
      default:     next_colour = COL_RED;
    endcase
  endfunction

endpackage

// File: rtl/piece_motion_scheduler_button_edge_latch.sv
// button_edge_latch: rising-edge detector with a pending flag.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   btn        : debounced button level
//   tick       : frame tick; consumes (clears) the pending flag
//   clr        : external clear while the FSM ignores buttons
//   hit        : pending flag OR an edge in this very cycle, so an edge
//                landing on the tick cycle is seen by that tick
module button_edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic tick,
  input  logic clr,
  output logic hit
);

  logic btn_q;
  logic pend;
  logic rise;

  assign rise = btn & ~btn_q;
  assign hit  = pend | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      btn_q <= btn;
      if (tick || clr) pend <= 1'b0;
      else if (rise)   pend <= 1'b1;
    end
  end

endmodule

// File: rtl/piece_motion_scheduler.sv
// piece_motion_scheduler: owns the falling sprite's X/Y offsets, colour and
// drop timing. Position changes are committed only on frame ticks.
// Ports:
//   Clock, Reset          : pixel clock, async active-low reset
//   iStart                : leave IDLE
//   iFrameTick            : one-cycle pulse at frame boundary
//   iLeft/iRight/iDrop    : debounced button levels
//   oXRedCounter/oYRedCounter : sprite offsets (10 bit)
//   oColorCuadro          : displayed colour (blinks white while landed)
//   oLanded, oBusy        : state flags
//   oPieceCount           : landed pieces, wraps at 256
module piece_motion_scheduler
  import piece_motion_scheduler_pkg::*;
#(
  parameter int STEP        = STEP_DEF,
  parameter int X_INIT      = 96,
  parameter int X_MAX       = 192,
  parameter int Y_INIT      = 0,
  parameter int Y_MAX       = 256,
  parameter int GRAV_FRAMES = 30,
  parameter int LAND_FRAMES = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iFrameTick,
  input  logic       iLeft,
  input  logic       iRight,
  input  logic       iDrop,
  output logic [9:0] oXRedCounter,
  output logic [9:0] oYRedCounter,
  output logic [2:0] oColorCuadro,
  output logic       oLanded,
  output logic       oBusy,
  output logic [7:0] oPieceCount
);

  localparam logic [9:0] STEP_W    = 10'(STEP);
  localparam logic [9:0] X_INIT_W  = 10'(X_INIT);
  localparam logic [9:0] X_MAX_W   = 10'(X_MAX);
  localparam logic [9:0] Y_INIT_W  = 10'(Y_INIT);
  localparam logic [9:0] Y_MAX_W   = 10'(Y_MAX);
  localparam logic [7:0] GRAV_LAST = 8'(GRAV_FRAMES - 1);
  localparam logic [8:0] LAND_W    = 9'(LAND_FRAMES);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [2:0] col_q, col_d, disp_q, disp_d;
  logic [7:0] grav_q, grav_d, land_q, land_d, cnt_q, cnt_d;
  logic       drop_q, drop_d;
  logic       landed_q, busy_q;
  logic [8:0] land_sum;

  // hit[0]=left, hit[1]=right, hit[2]=drop
  logic [2:0] btn, hit;
  logic       btn_clr;

  assign btn     = {iDrop, iRight, iLeft};
  assign btn_clr = (state_q == ST_IDLE) || (state_q == ST_LANDED);

  for (genvar i = 0; i < 3; i++) begin : g_btn
    button_edge_latch u_bel (
      .clk   (Clock),
      .rst_n (Reset),
      .btn   (btn[i]),
      .tick  (iFrameTick),
      .clr   (btn_clr),
      .hit   (hit[i])
    );
  end

  assign land_sum = {1'b0, land_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    disp_d  = disp_q;
    grav_d  = grav_q;
    land_d  = land_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: if (iStart) state_d = ST_SPAWN;
      ST_SPAWN: begin
        x_d     = X_INIT_W;
        y_d     = Y_INIT_W;
        grav_d  = '0;
        drop_d  = 1'b0;
        state_d = ST_FALLING;
      end
      ST_FALLING: if (iFrameTick) begin
        if (hit[0] && !hit[1]) begin
          if (x_q != '0) x_d = x_q - STEP_W;
        end else if (hit[1] && !hit[0]) begin
          if (x_q < X_MAX_W) x_d = x_q + STEP_W;
        end
        if (hit[2]) drop_d = 1'b1;
        // Drop mode takes effect on the same tick it is requested.
        if (drop_d || grav_q == GRAV_LAST) begin
          grav_d = '0;
          if (y_q < Y_MAX_W) y_d = y_q + STEP_W;
          else begin
            state_d = ST_LANDED;
            land_d  = '0;
            cnt_d   = cnt_q + 8'd1;
          end
        end else begin
          grav_d = grav_q + 8'd1;
        end
      end
      ST_LANDED: if (iFrameTick) begin
        land_d = land_sum[7:0];
        if (land_sum == LAND_W) begin
          col_d   = next_colour(col_q);
          disp_d  = col_d;
          state_d = ST_SPAWN;
        end else begin
          disp_d = (disp_q == col_q) ? COL_WHITE : col_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      x_q      <= X_INIT_W;
      y_q      <= Y_INIT_W;
      col_q    <= COL_RED;
      disp_q   <= COL_RED;
      grav_q   <= '0;
      land_q   <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      landed_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      disp_q   <= disp_d;
      grav_q   <= grav_d;
      land_q   <= land_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      landed_q <= (state_d == ST_LANDED);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign oXRedCounter = x_q;
  assign oYRedCounter = y_q;
  assign oColorCuadro = disp_q;
  assign oLanded      = landed_q;
  assign oBusy        = busy_q;
  assign oPieceCount  = cnt_q;

endmodule

// File: tb/tb_piece_motion_scheduler.sv
// Self-checking bench for piece_motion_scheduler with default parameters.
// A behavioural model tracks the sprite per clock; each scenario task also
// checks the concrete values the behaviour calls for.
module tb_piece_motion_scheduler;

  localparam int GRAV = 30;
  localparam int LAND = 8;

  logic       Clock, Reset, iStart, iFrameTick, iLeft, iRight, iDrop;
  logic [9:0] oXRedCounter, oYRedCounter;
  logic [2:0] oColorCuadro;
  logic       oLanded, oBusy;
  logic [7:0] oPieceCount;

  int compared   = 0;
  int mismatched = 0;

  piece_motion_scheduler dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStart       (iStart),
    .iFrameTick   (iFrameTick),
    .iLeft        (iLeft),
    .iRight       (iRight),
    .iDrop        (iDrop),
    .oXRedCounter (oXRedCounter),
    .oYRedCounter (oYRedCounter),
    .oColorCuadro (oColorCuadro),
    .oLanded      (oLanded),
    .oBusy        (oBusy),
    .oPieceCount  (oPieceCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  logic [2:0] ctab [6] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101};
  int mx, my, m_st, m_ci, m_grav, m_land, m_cnt;  // m_st: 0 idle,1 spawn,2 fall,3 landed
  bit m_blink, m_drop, pl, pr, pd, ql, qr, qd;

  always @(posedge Clock or negedge Reset) begin : mdl
    bit el, er, ed, hl, hr, hd;
    int st0;
    if (!Reset) begin
      m_st = 0; mx = 96; my = 0; m_ci = 0; m_blink = 0; m_grav = 0;
      m_land = 0; m_cnt = 0; m_drop = 0;
      pl = 0; pr = 0; pd = 0; ql = 0; qr = 0; qd = 0;
    end else begin
      el = iLeft && !ql; er = iRight && !qr; ed = iDrop && !qd;
      hl = pl || el; hr = pr || er; hd = pd || ed;
      st0 = m_st;
      case (m_st)
        0: if (iStart) m_st = 1;
        1: begin mx = 96; my = 0; m_grav = 0; m_drop = 0; m_st = 2; end
        2: if (iFrameTick) begin
          if (hl && !hr) begin if (mx > 0) mx -= 32; end
          else if (hr && !hl) begin if (mx < 192) mx += 32; end
          if (hd) m_drop = 1;
          if (m_drop || m_grav == GRAV - 1) begin
            m_grav = 0;
            if (my < 256) my += 32;
            else begin m_st = 3; m_land = 0; m_cnt = (m_cnt + 1) % 256; m_blink = 0; end
          end else m_grav++;
        end
        default: if (iFrameTick) begin
          m_land++;
          if (m_land == LAND) begin m_ci = (m_ci + 1) % 6; m_blink = 0; m_st = 1; end
          else m_blink = !m_blink;
        end
      endcase
      if (iFrameTick || st0 == 0 || st0 == 3) begin pl = 0; pr = 0; pd = 0; end
      else begin pl |= el; pr |= er; pd |= ed; end
      ql = iLeft; qr = iRight; qd = iDrop;
    end
  end

  wire [32:0] dut_vec = {oXRedCounter, oYRedCounter, oColorCuadro, oLanded, oBusy, oPieceCount};
  wire [32:0] mdl_vec = {mx[9:0], my[9:0], (m_blink ? 3'b111 : ctab[m_ci]),
                         (m_st == 3), (m_st != 0), m_cnt[7:0]};

  // Drive one cycle of inputs from a negedge, return at the next negedge.
  task automatic cyc(input bit s, input bit t, input bit l, input bit r, input bit d);
    iStart = s; iFrameTick = t; iLeft = l; iRight = r; iDrop = d;
    @(negedge Clock);
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    Reset = 1'b1;
    cyc(0, 1, 0, 1, 0);
    compared++;
    if (dut_vec !== {10'd96, 10'd0, 3'b100, 1'b0, 1'b0, 8'd0}) begin
      mismatched++; $display("FAIL reset_state: got %h want %h", dut_vec, {10'd96, 10'd0, 3'b100, 1'b0, 1'b0, 8'd0});
    end
    compared++;
    if (dut_vec !== mdl_vec) begin
      mismatched++; $display("FAIL reset_model: got %h want %h", dut_vec, mdl_vec);
    end
  endtask

  task automatic test_gravity;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    compared++;
    if (oBusy !== 1'b1) begin mismatched++; $display("FAIL gravity_busy: got %b want 1", oBusy); end
    for (int k = 1; k <= 31; k++) begin
      cyc(0, 1, 0, 0, 0);
      compared++;
      if (oYRedCounter !== ((k < 30) ? 10'd0 : 10'd32)) begin
        mismatched++; $display("FAIL gravity_y tick%0d: got %0d want %0d", k, oYRedCounter, (k < 30) ? 0 : 32);
      end
      compared++;
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL gravity_model: got %h want %h", dut_vec, mdl_vec); end
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_horizontal;
    logic [9:0] want [6] = '{10'd128, 10'd160, 10'd192, 10'd192, 10'd192, 10'd160};
    for (int k = 0; k < 6; k++) begin
      case (k)
        4: begin cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 0); cyc(0, 1, 0, 0, 0); end
        5: begin cyc(0, 0, 0, 0, 0); cyc(0, 1, 1, 0, 0); end
        default: begin cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); end
      endcase
      compared++;
      if (oXRedCounter !== want[k]) begin
        mismatched++; $display("FAIL horiz_x step%0d: got %0d want %0d", k, oXRedCounter, want[k]);
      end
      compared++;
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL horiz_model: got %h want %h", dut_vec, mdl_vec); end
    end
  endtask

  task automatic test_reset_mid_fall;
    Reset = 1'b0; cyc(0, 0, 0, 0, 0); Reset = 1'b1; cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1); cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0); cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    compared++;
    if ({oXRedCounter, oYRedCounter} !== {10'd160, 10'd96}) begin
      mismatched++; $display("FAIL midfall_setup: got x=%0d y=%0d want x=160 y=96", oXRedCounter, oYRedCounter);
    end
    Reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    compared++;
    if (dut_vec !== {10'd96, 10'd0, 3'b100, 1'b0, 1'b0, 8'd0}) begin
      mismatched++; $display("FAIL midfall_reset: got %h want %h", dut_vec, {10'd96, 10'd0, 3'b100, 1'b0, 1'b0, 8'd0});
    end
    Reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_drop_land;
    cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 1, 0, 0, 0);
      compared++;
      if ({oYRedCounter, oLanded, oPieceCount} !== {10'((k < 9 ? k : 8) * 32), k == 9, 8'(k == 9)}) begin
        mismatched++; $display("FAIL drop_tick%0d: got y=%0d landed=%b cnt=%0d", k, oYRedCounter, oLanded, oPieceCount);
      end
      cyc(0, 0, 0, 0, 0);
    end
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 0, 0, 0);
      compared++;
      if ({oColorCuadro, oLanded} !== ((k == 8) ? {3'b010, 1'b0} : {((k % 2) ? 3'b111 : 3'b100), 1'b1})) begin
        mismatched++; $display("FAIL land_tick%0d: got col=%b landed=%b", k, oColorCuadro, oLanded);
      end
      compared++;
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL land_model: got %h want %h", dut_vec, mdl_vec); end
    end
    cyc(0, 0, 0, 0, 0);
    compared++;
    if ({oXRedCounter, oYRedCounter, oColorCuadro, oBusy} !== {10'd96, 10'd0, 3'b010, 1'b1}) begin
      mismatched++; $display("FAIL respawn: got x=%0d y=%0d col=%b busy=%b", oXRedCounter, oYRedCounter, oColorCuadro, oBusy);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) Reset = 1'b0;
      if (n == 1002) Reset = 1'b1;
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      compared++;
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL random_model cyc%0d: got %h want %h", n, dut_vec, mdl_vec); end
    end
  endtask

  task automatic test_wrap;
    int pieces = 0;
    bit prev_landed = 0;
    Reset = 1'b0; cyc(0, 0, 0, 0, 0); Reset = 1'b1; cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int f = 0; f < 256 * 20 && pieces < 256; f++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0);
      if (oLanded && !prev_landed) begin
        pieces++;
        compared++;
        if (oPieceCount !== 8'(pieces)) begin
          mismatched++; $display("FAIL wrap_count: got %0d want %0d", oPieceCount, pieces % 256);
        end
      end
      if (!oLanded && prev_landed) begin
        compared++;
        if (oColorCuadro !== ctab[pieces % 6]) begin
          mismatched++; $display("FAIL wrap_colour piece%0d: got %b want %b", pieces, oColorCuadro, ctab[pieces % 6]);
        end
      end
      prev_landed = oLanded;
      compared++;
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL wrap_model: got %h want %h", dut_vec, mdl_vec); end
    end
    compared++;
    if (pieces != 256 || oPieceCount !== 8'd0) begin
      mismatched++; $display("FAIL wrap_final: got pieces=%0d cnt=%0d want 256 and 0", pieces, oPieceCount);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0; iStart = 0; iFrameTick = 0; iLeft = 0; iRight = 0; iDrop = 0;
    @(negedge Clock);
    test_reset;
    test_gravity;
    test_horizontal;
    test_reset_mid_fall;
    test_drop_land;
    test_random;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/piece_motion_scheduler.md
Name: piece_motion_scheduler

Overview:
- Sequences the falling-piece sprite drawn by the VGA controller: owns the X/Y offset pair, the piece colour and the drop timing.
- All position updates are committed only on the frame-boundary tick, so the sprite never tears mid-frame.
- Sits between the debounced button inputs and the VGA controller's iXRedCounter/iYRedCounter/iColorCuadro inputs.

Parameters:
STEP, 32, pixels moved per horizontal or vertical step
X_INIT, 96, X offset on spawn
X_MAX, 192, largest legal X offset (X_MAX mod STEP = 0)
Y_INIT, 0, Y offset on spawn
Y_MAX, 256, landing Y offset (Y_MAX mod STEP = 0)
GRAV_FRAMES, 30, frames per gravity step (range 1..255)
LAND_FRAMES, 8, frames held in LANDED before respawn (range 1..255)

Ports:
Clock  in  1  system pixel clock
Reset  in  1  asynchronous, active-low reset
iStart  in  1  level; starts play from IDLE
iFrameTick  in  1  one-cycle pulse at vertical-counter wrap
iLeft  in  1  debounced button, level
iRight  in  1  debounced button, level
iDrop  in  1  debounced button, level
oXRedCounter  out  10  sprite X offset
oYRedCounter  out  10  sprite Y offset
oColorCuadro  out  3  sprite colour
oLanded  out  1  high while in LANDED
oBusy  out  1  high in any state except IDLE
oPieceCount  out  8  pieces landed, wraps 255->0

Behaviour:
- Reset (Reset=0, async): state IDLE, X=X_INIT, Y=Y_INIT, colour=3'b100, gravity counter=0, land counter=0, all pending requests cleared, oPieceCount=0, oLanded=0, oBusy=0.
- All outputs are registered. An update committed on a tick cycle is visible on the next cycle.
- Button front end: each of iLeft/iRight/iDrop is rising-edge detected against its previous-cycle value. An edge sets a pending flag, and the flag holds until the next tick.
  - An edge arriving on the tick cycle itself is included in that tick.
  - Pending flags clear on every tick, and in IDLE and LANDED.
- States:
  - IDLE: iStart=1 -> SPAWN. Ticks and buttons are ignored.
  - SPAWN (one cycle): X=X_INIT, Y=Y_INIT, gravity counter=0, drop mode=0 -> FALLING.
  - FALLING, on tick:
    1. Horizontal move. Left and right both pending: no move. Left only: X-=STEP if X>0. Right only: X+=STEP if X<X_MAX. Blocked moves are dropped silently.
    2. Drop pending: drop mode=1, which acts as a gravity period of 1 until landing.
    3. Gravity counter increments. Gravity is due when the counter reaches GRAV_FRAMES-1 (or when drop mode=1). When due, the counter resets to 0 and Y+=STEP if Y<Y_MAX. If Y==Y_MAX when due, go to LANDED and Y is unchanged.
    - Cycles without a tick change nothing except the pending flags.
  - LANDED:
    - On entry: oPieceCount+=1, land counter=0.
    - Each tick: land counter+=1, and oColorCuadro toggles between the piece colour and 3'b111.
    - When the land counter reaches LAND_FRAMES: advance the colour through 100->010->001->110->011->101->100, restore the true colour, then -> SPAWN.
- iStart outside IDLE is ignored. There is no return to IDLE except by reset.
- Width rule: X and Y are 10-bit unsigned. The design guarantees they never exceed X_MAX and Y_MAX, so no wrap-around is possible.
- Reset asserted mid-fall or mid-LANDED returns immediately to the reset values listed above.

Decomposition:
- Shared package/include, alongside the existing colour definitions:
  - FSM state encodings (IDLE, SPAWN, FALLING, LANDED).
  - Colour rotation constants, reusing the existing colour macros.
  - Default STEP.
- One natural sub-module, button_edge_latch: edge detector plus pending flag, cleared by tick or an external clear. It is instanced three times.

Test Plan:
- Reset low mid-FALLING at X=160, Y=96 -> next cycle X=96, Y=0, colour=100, oBusy=0, oPieceCount=0.
- iStart, then 31 ticks with GRAV_FRAMES=30 -> Y=32 after tick 30, still 32 after tick 31. Outputs change exactly one cycle after the tick.
- In FALLING with X=192: press iRight -> X stays 192. Press iLeft and iRight in the same frame -> X unchanged. Press iLeft on the tick cycle itself -> X=160 one cycle later.
- iDrop at Y=0 -> Y advances 32 per tick and reaches 256 after 8 ticks; next tick gives oLanded=1 and oPieceCount=1.
- LANDED with LAND_FRAMES=8: colour alternates 100/111 on each tick; after 8 ticks it goes to SPAWN with colour 010, X=96, Y=0, oLanded=0.
- Start 256 pieces in drop mode -> oPieceCount wraps to 0, and the colour sequence repeats with period 6.
